eth_rx_frame_ctl: RTL and testbench

Receive-side frame controller that sits directly behind the RMII receiver.
- Consumes the receiver's byte stream (data/valid/sop/eop).
- Sequences bytes into an internal circular byte buffer and checks FCS and length.
- Commits good frames as a single-entry descriptor with a valid/ready handshake; drops bad frames without moving the committed write pointer.
- A downstream consumer (DMA/CPU bridge) reads the buffer and returns space by advancing rd_ptr.

---
 rtl/eth_pkg.sv | 29 ++
 rtl/eth_crc32.sv | 32 +++
 rtl/eth_rx_frame_ctl.sv | 167 ++++++++++++++++
 tb/tb_eth_rx_frame_ctl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types, CRC-32 constants and small helpers for the Ethernet MAC datapaths.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP,
        COMMIT
    } rx_ctl_state_t;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    // One byte of the reflected CRC-32, LSB of the byte first as it arrives on the wire.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 register; shared by the RX checker and the TX FCS generator.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc;
        if (init) begin
            crc_next = CRC32_INIT;
        end else if (en) begin
            crc_next = crc32_byte(crc, data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc <= CRC32_INIT;
        end else begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/eth_rx_frame_ctl.sv
// Receive frame controller: buffers RMII bytes, checks length/FCS and publishes
// good frames through a single-entry descriptor.
module eth_rx_frame_ctl
    import eth_pkg::*;
#(
    parameter int BUF_AW  = 12,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              en,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_sop,
    input  logic              rx_eop,
    input  logic [BUF_AW-1:0] rd_ptr,
    input  logic [BUF_AW-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [BUF_AW-1:0] desc_addr,
    output logic [10:0]       desc_len,
    output logic [15:0]       cnt_ok,
    output logic [15:0]       cnt_crc,
    output logic [15:0]       cnt_len,
    output logic [15:0]       cnt_drop
);

    localparam int          DEPTH     = 1 << BUF_AW;
    localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);

    rx_ctl_state_t     state;
    logic [BUF_AW-1:0] wr_ptr;
    logic [BUF_AW-1:0] wr_tmp;
    logic [BUF_AW-1:0] wr_next;
    logic [10:0]       len;
    logic [31:0]       crc;
    logic [7:0]        mem [DEPTH];
    logic              buf_full;
    logic              len_max;
    logic              byte_ok;

    // One slot stays empty so that wr == rd always means "empty".
    assign wr_next  = wr_tmp + 1'b1;
    assign buf_full = (wr_next == rd_ptr);
    assign len_max  = (len == MAX_LEN_L);
    assign byte_ok  = (state == RECV) && rx_valid && !rx_sop && !rx_eop && !len_max && !buf_full;

    eth_crc32 u_crc (
        .clk   (clk50),
        .reset (reset),
        .init  (rx_sop),
        .en    (byte_ok),
        .data  (rx_data),
        .crc   (crc)
    );

    always_ff @(posedge clk50) begin
        if (byte_ok) begin
            mem[wr_tmp] <= rx_data;
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            wr_tmp     <= '0;
            len        <= '0;
            desc_valid <= 1'b0;
            desc_addr  <= '0;
            desc_len   <= '0;
            cnt_ok     <= '0;
            cnt_crc    <= '0;
            cnt_len    <= '0;
            cnt_drop   <= '0;
        end else begin
            if (desc_valid && desc_ready) begin
                desc_valid <= 1'b0;
            end

            case (state)
                RECV: begin
                    if (rx_sop) begin
                        // Preamble error from the receiver: restart from the committed pointer.
                        wr_tmp <= wr_ptr;
                        len    <= '0;
                        if (len != '0) begin
                            cnt_len <= sat_inc16(cnt_len);
                        end
                    end else if (rx_eop) begin
                        state <= IDLE;
                        if (len < MIN_LEN_L) begin
                            cnt_len <= sat_inc16(cnt_len);
                        end else if (crc != CRC32_RESIDUE) begin
                            cnt_crc <= sat_inc16(cnt_crc);
                        end else if (desc_valid && !desc_ready) begin
                            cnt_drop <= sat_inc16(cnt_drop);
                        end else begin
                            state <= COMMIT;
                        end
                    end else if (rx_valid) begin
                        if (len_max) begin
                            state   <= DROP;
                            cnt_len <= sat_inc16(cnt_len);
                        end else if (buf_full) begin
                            state    <= DROP;
                            cnt_drop <= sat_inc16(cnt_drop);
                        end else begin
                            wr_tmp <= wr_next;
                            len    <= len + 11'd1;
                        end
                    end
                end

                COMMIT: begin
                    desc_valid <= 1'b1;
                    desc_addr  <= wr_ptr;
                    desc_len   <= len;
                    wr_ptr     <= wr_tmp;
                    cnt_ok     <= sat_inc16(cnt_ok);
                    state      <= IDLE;
                    // wr_tmp already equals the new wr_ptr, so a back-to-back frame starts there.
                    if (rx_sop) begin
                        if (en) begin
                            state <= RECV;
                            len   <= '0;
                        end else begin
                            state    <= DROP;
                            cnt_drop <= sat_inc16(cnt_drop);
                        end
                    end
                end

                IDLE, DROP: begin
                    if (rx_sop) begin
                        if (en) begin
                            state  <= RECV;
                            wr_tmp <= wr_ptr;
                            len    <= '0;
                        end else begin
                            state    <= DROP;
                            cnt_drop <= sat_inc16(cnt_drop);
                        end
                    end else if (rx_eop) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_ctl.sv
// Frame-level randomised bench for eth_rx_frame_ctl; descriptors are checked by a
// scoreboard monitor, counters and buffer contents by the stimulus process.
module tb_eth_rx_frame_ctl;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int MINL  = 64;
    localparam int MAXL  = 100;

    localparam int K_GOOD    = 0;
    localparam int K_BAD     = 1;
    localparam int K_NOEN    = 2;
    localparam int K_RESTART = 3;
    localparam int K_RESET   = 4;

    typedef logic [7:0] byte_t;
    typedef struct {
        int addr;
        int len;
    } desc_t;

    logic          clk50 = 1'b0;
    logic          reset;
    logic          en;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_sop;
    logic          rx_eop;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          desc_valid;
    logic          desc_ready;
    logic [AW-1:0] desc_addr;
    logic [10:0]   desc_len;
    logic [15:0]   cnt_ok;
    logic [15:0]   cnt_crc;
    logic [15:0]   cnt_len;
    logic [15:0]   cnt_drop;

    int    tests_run = 0;
    int    failures  = 0;
    desc_t exp_q[$];
    desc_t mon_e;
    byte_t frame_q[$];
    byte_t prefix_q[$];

    // Reference model: buffer pointers, pending descriptor and statistics.
    int    m_wr, m_rd, m_rel;
    int    m_ok, m_crc, m_len, m_drop;
    bit    m_pend;
    int    m_pend_addr, m_pend_len;
    byte_t m_pend_bytes[$];

    eth_rx_frame_ctl #(
        .BUF_AW  (AW),
        .MIN_LEN (MINL),
        .MAX_LEN (MAXL)
    ) dut (
        .clk50      (clk50),
        .reset      (reset),
        .en         (en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sop     (rx_sop),
        .rx_eop     (rx_eop),
        .rd_ptr     (rd_ptr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_addr  (desc_addr),
        .desc_len   (desc_len),
        .cnt_ok     (cnt_ok),
        .cnt_crc    (cnt_crc),
        .cnt_len    (cnt_len),
        .cnt_drop   (cnt_drop)
    );

    always #10 clk50 = ~clk50;

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Descriptor scoreboard: every accepted descriptor must match the oldest committed frame.
    always @(negedge clk50) begin
        if (!reset && desc_valid && desc_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("desc_unexpected", 32'(desc_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("desc_addr", 32'(desc_addr), 32'(mon_e.addr));
                checkOutput("desc_len", 32'(desc_len), 32'(mon_e.len));
            end
        end
    end

    function automatic int sat(input int c);
        return (c < 65535) ? c + 1 : c;
    endfunction

    function automatic logic [31:0] crc_of(input byte_t q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [31:0] fcs;
        int          idx;
        frame_q.delete();
        for (int i = 0; i < n - 4; i++) begin
            frame_q.push_back(byte_t'($urandom_range(0, 255)));
        end
        fcs = crc_of(frame_q);
        for (int i = 0; i < 4; i++) begin
            frame_q.push_back(fcs[8*i +: 8]);
        end
        if (corrupt) begin
            idx          = $urandom_range(0, n - 1);
            frame_q[idx] = frame_q[idx] ^ byte_t'($urandom_range(1, 255));
        end
    endtask

    function automatic void model_reset();
        m_wr   = 0;
        m_rd   = 0;
        m_rel  = 0;
        m_ok   = 0;
        m_crc  = 0;
        m_len  = 0;
        m_drop = 0;
        m_pend = 0;
        exp_q.delete();
    endfunction

    // Bytes the frame gets to store before it is cut off by the length limit or a full buffer.
    function automatic int model_bytes(input int n, output bit dropped);
        int space;
        space   = (m_rd - m_wr - 1) & (DEPTH - 1);
        dropped = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == MAXL) begin
                m_len   = sat(m_len);
                dropped = 1'b1;
                return i;
            end
            if (i == space) begin
                m_drop  = sat(m_drop);
                dropped = 1'b1;
                return i;
            end
        end
        return n;
    endfunction

    function automatic bit model_end(input int n, input bit bad);
        desc_t d;
        if (n < MINL) begin
            m_len = sat(m_len);
        end else if (bad) begin
            m_crc = sat(m_crc);
        end else if (m_pend) begin
            m_drop = sat(m_drop);
        end else begin
            d.addr = m_wr;
            d.len  = n;
            exp_q.push_back(d);
            m_pend       = 1'b1;
            m_pend_addr  = m_wr;
            m_pend_len   = n;
            m_pend_bytes = frame_q;
            m_wr         = (m_wr + n) % DEPTH;
            m_ok         = sat(m_ok);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive_sop(input logic en_at_sop);
        rx_sop = 1'b1;
        en     = en_at_sop;
        tick();
        rx_sop = 1'b0;
        en     = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_bytes(input byte_t q[$]);
        foreach (q[i]) begin
            if ($urandom_range(0, 7) == 0) begin
                rx_valid = 1'b0;
                tick();
            end
            rx_valid = 1'b1;
            rx_data  = q[i];
            tick();
        end
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int kind, input int n, input int pre_n, input bit b2b);
        int written;
        bit dropped;
        bit commit;
        bit bad;
        commit = 1'b0;
        bad    = (kind == K_BAD);
        build_frame(n, bad);
        case (kind)
            K_NOEN: begin
                drive_sop(1'b0);
                m_drop = sat(m_drop);
                drive_bytes(frame_q);
                rx_eop = 1'b1;
                tick();
                rx_eop = 1'b0;
            end
            K_RESET: begin
                drive_sop(1'b1);
                prefix_q.delete();
                for (int i = 0; i < pre_n; i++) prefix_q.push_back(frame_q[i]);
                drive_bytes(prefix_q);
                reset  = 1'b1;
                rd_ptr = '0;
                tick();
                tick();
                reset = 1'b0;
                model_reset();
            end
            default: begin
                drive_sop(1'b1);
                if (kind == K_RESTART) begin
                    prefix_q.delete();
                    for (int i = 0; i < pre_n; i++) prefix_q.push_back(byte_t'($urandom_range(0, 255)));
                    drive_bytes(prefix_q);
                    written = model_bytes(pre_n, dropped);
                    if (!dropped && written > 0) m_len = sat(m_len);
                    drive_sop(1'b1);
                end
                drive_bytes(frame_q);
                written = model_bytes(n, dropped);
                rx_eop = 1'b1;
                tick();
                rx_eop = 1'b0;
                if (!dropped) commit = model_end(n, bad);
            end
        endcase
        if (!b2b) begin
            if (commit) begin
                checkOutput("desc_valid_eop+1", 32'(desc_valid), 32'd0);
                tick();
                checkOutput("desc_valid_eop+2", 32'(desc_valid), 32'd1);
                checkOutput("desc_addr_eop+2", 32'(desc_addr), 32'(m_pend_addr));
                checkOutput("desc_len_eop+2", 32'(desc_len), 32'(m_pend_len));
            end else begin
                tick();
            end
            tick();
        end
    endtask

    task automatic idle_phase(input bit accept, input bit release_buf);
        checkOutput("cnt_ok", 32'(cnt_ok), 32'(m_ok));
        checkOutput("cnt_crc", 32'(cnt_crc), 32'(m_crc));
        checkOutput("cnt_len", 32'(cnt_len), 32'(m_len));
        checkOutput("cnt_drop", 32'(cnt_drop), 32'(m_drop));
        checkOutput("desc_valid_idle", 32'(desc_valid), 32'(m_pend));
        if (accept && m_pend) begin
            desc_ready = 1'b1;
            tick();
            desc_ready = 1'b0;
            checkOutput("desc_valid_after_ack", 32'(desc_valid), 32'd0);
            for (int i = 0; i < m_pend_len; i++) begin
                rd_addr = AW'((m_pend_addr + i) % DEPTH);
                tick();
                checkOutput("rd_data", 32'(rd_data), 32'(m_pend_bytes[i]));
            end
            m_pend = 1'b0;
            m_rel  = (m_pend_addr + m_pend_len) % DEPTH;
        end
        if (release_buf) begin
            m_rd   = m_rel;
            rd_ptr = AW'(m_rd);
        end
    endtask

    initial begin
        int r, n, kind, pre;
        bit b2b;

        reset      = 1'b1;
        en         = 1'b0;
        rx_data    = '0;
        rx_valid   = 1'b0;
        rx_sop     = 1'b0;
        rx_eop     = 1'b0;
        rd_ptr     = '0;
        rd_addr    = '0;
        desc_ready = 1'b0;
        model_reset();
        tick();
        tick();
        tick();
        checkOutput("rst_desc_valid", 32'(desc_valid), 32'd0);
        checkOutput("rst_desc_addr", 32'(desc_addr), 32'd0);
        checkOutput("rst_desc_len", 32'(desc_len), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        checkOutput("rst_cnt_ok", 32'(cnt_ok), 32'd0);
        checkOutput("rst_cnt_crc", 32'(cnt_crc), 32'd0);
        checkOutput("rst_cnt_len", 32'(cnt_len), 32'd0);
        checkOutput("rst_cnt_drop", 32'(cnt_drop), 32'd0);
        reset = 1'b0;
        tick();

        // Directed scenarios: good, bad FCS, fill to overflow, restart, busy slot, bounds, reset.
        applyStimulus(K_GOOD, 64, 0, 1'b0);     idle_phase(1'b1, 1'b1);
        applyStimulus(K_BAD, 64, 0, 1'b0);      idle_phase(1'b0, 1'b0);
        applyStimulus(K_GOOD, 64, 0, 1'b0);     idle_phase(1'b1, 1'b1);
        applyStimulus(K_GOOD, 100, 0, 1'b0);    idle_phase(1'b1, 1'b0);
        applyStimulus(K_GOOD, 100, 0, 1'b0);    idle_phase(1'b1, 1'b0);
        applyStimulus(K_GOOD, 64, 0, 1'b0);     idle_phase(1'b0, 1'b1);
        applyStimulus(K_GOOD, 64, 0, 1'b0);     idle_phase(1'b1, 1'b1);
        applyStimulus(K_RESTART, 64, 0, 1'b0);  idle_phase(1'b1, 1'b1);
        applyStimulus(K_RESTART, 70, 3, 1'b0);  idle_phase(1'b1, 1'b1);
        applyStimulus(K_GOOD, 64, 0, 1'b0);     idle_phase(1'b0, 1'b0);
        applyStimulus(K_GOOD, 64, 0, 1'b0);     idle_phase(1'b1, 1'b1);
        applyStimulus(K_GOOD, MINL - 1, 0, 1'b0); idle_phase(1'b1, 1'b1);
        applyStimulus(K_GOOD, MINL, 0, 1'b0);   idle_phase(1'b1, 1'b1);
        applyStimulus(K_GOOD, MAXL + 1, 0, 1'b0); idle_phase(1'b1, 1'b1);
        applyStimulus(K_NOEN, 64, 0, 1'b0);     idle_phase(1'b1, 1'b1);
        applyStimulus(K_GOOD, 64, 0, 1'b1);
        applyStimulus(K_GOOD, 64, 0, 1'b0);     idle_phase(1'b1, 1'b1);
        applyStimulus(K_RESET, 64, 20, 1'b0);   idle_phase(1'b1, 1'b1);
        applyStimulus(K_GOOD, 64, 0, 1'b0);     idle_phase(1'b1, 1'b1);

        for (int it = 0; it < 40; it++) begin
            r   = $urandom_range(0, 99);
            pre = 0;
            if (r < 40) begin
                kind = K_GOOD;    n = $urandom_range(MINL, MAXL);
            end else if (r < 55) begin
                kind = K_BAD;     n = $urandom_range(MINL, MAXL);
            end else if (r < 65) begin
                kind = K_GOOD;    n = $urandom_range(8, MINL - 1);
            end else if (r < 70) begin
                kind = K_GOOD;    n = $urandom_range(MAXL + 1, MAXL + 4);
            end else if (r < 80) begin
                kind = K_NOEN;    n = $urandom_range(8, MAXL);
            end else if (r < 95) begin
                kind = K_RESTART; n = $urandom_range(MINL, MAXL); pre = $urandom_range(0, 6);
            end else begin
                kind = K_RESET;   n = 64; pre = $urandom_range(1, 40);
            end
            b2b = (kind != K_RESET) && ($urandom_range(0, 4) == 0);
            applyStimulus(kind, n, pre, b2b);
            if (!b2b) idle_phase($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end

        tick();
        tick();
        tick();
        idle_phase(1'b1, 1'b1);
        checkOutput("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
